// File: rtl/cache_fill_ctrl_pkg.sv
// Shared definitions for the cache fill controller: FSM encoding and the
// width derivations that depend on the block geometry.
package cache_fill_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_FILL = 2'd2,
    ST_TAG  = 2'd3
  } fill_state_e;

  // Bits needed to index a word inside a block.
  function automatic int unsigned idx_width(input int unsigned block_words);
    return $clog2(block_words);
  endfunction

  // Byte-offset bits covered by one block; cleared to form a block base.
  function automatic int unsigned off_width(input int unsigned block_words,
                                            input int unsigned word_bytes);
    return $clog2(block_words * word_bytes);
  endfunction

  // Shift turning a word index into a byte offset.
  function automatic int unsigned byte_width(input int unsigned word_bytes);
    return $clog2(word_bytes);
  endfunction

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// Miss/memory/array handshake bundle between the fill controller and the
// tag logic, memory port and cache arrays.
interface cache_fill_ctrl_if #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned BLOCK_WORDS = 8
);
  import cache_fill_ctrl_pkg::*;

  localparam int unsigned IDX_W = idx_width(BLOCK_WORDS);

  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              victim_dirty;
  logic [ADDR_W-1:0] victim_address;
  logic              memory_data_valid;
  logic              mem_wr_ack;

  logic              fsm_busy;
  logic              mem_rd_req;
  logic              mem_wr_req;
  logic [ADDR_W-1:0] memory_address;
  logic              read_data_array;
  logic              write_data_array;
  logic              write_tag_array;
  logic [IDX_W-1:0]  array_word_idx;
  logic              fill_done;

  modport master (
    input  miss_detected, miss_address, victim_dirty, victim_address,
           memory_data_valid, mem_wr_ack,
    output fsm_busy, mem_rd_req, mem_wr_req, memory_address,
           read_data_array, write_data_array, write_tag_array,
           array_word_idx, fill_done
  );

  modport slave (
    output miss_detected, miss_address, victim_dirty, victim_address,
           memory_data_valid, mem_wr_ack,
    input  fsm_busy, mem_rd_req, mem_wr_req, memory_address,
           read_data_array, write_data_array, write_tag_array,
           array_word_idx, fill_done
  );

endinterface

// File: rtl/cache_word_counter.sv
// Word index within a block; wraps to zero after the last word so the next
// phase starts at index 0 without an explicit clear.
module cache_word_counter #(
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o
);

  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr_i)      idx_d = '0;
    else if (inc_i) idx_d = idx_q + IDX_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idx_q <= '0;
    else     idx_q <= idx_d;
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == {IDX_W{1'b1}});

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache miss handler: optional dirty-victim write-back, block fill from
// memory, then tag install with a one-cycle fill_done pulse.
module cache_fill_ctrl
  import cache_fill_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned WORD_BYTES  = 2,
  parameter int unsigned BLOCK_WORDS = 8
) (
  input logic               clk,
  input logic               rst,
  cache_fill_ctrl_if.master bus
);

  localparam int unsigned IDX_W  = idx_width(BLOCK_WORDS);
  localparam int unsigned OFF_W  = off_width(BLOCK_WORDS, WORD_BYTES);
  localparam int unsigned BYTE_W = byte_width(WORD_BYTES);
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);

  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:0] miss_base_q, miss_base_d;
  logic [ADDR_W-1:0] victim_base_q, victim_base_d;

  logic [IDX_W-1:0]  idx;
  logic              idx_last;
  logic              cnt_clr, cnt_inc;
  logic [ADDR_W-1:0] word_off;

  logic              busy_c, rd_req_c, wr_req_c, rd_arr_c, wr_arr_c, tag_c, done_c;
  logic [ADDR_W-1:0] addr_c;
  logic [IDX_W-1:0]  arr_idx_c;

  cache_word_counter #(.IDX_W(IDX_W)) u_word_counter (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .idx_o  (idx),
    .last_o (idx_last)
  );

  assign word_off = ADDR_W'(idx) << BYTE_W;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      miss_base_q   <= '0;
      victim_base_q <= '0;
    end else begin
      state_q       <= state_d;
      miss_base_q   <= miss_base_d;
      victim_base_q <= victim_base_d;
    end
  end

  // Next state and decoded outputs; handshake inputs only matter in their own state.
  always_comb begin
    state_d       = state_q;
    miss_base_d   = miss_base_q;
    victim_base_d = victim_base_q;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    busy_c        = 1'b0;
    rd_req_c      = 1'b0;
    wr_req_c      = 1'b0;
    rd_arr_c      = 1'b0;
    wr_arr_c      = 1'b0;
    tag_c         = 1'b0;
    done_c        = 1'b0;
    addr_c        = '0;
    arr_idx_c     = '0;

    case (state_q)
      ST_IDLE: begin
        // rst gate keeps fsm_busy low while reset is held with a miss pending
        if (bus.miss_detected && !rst) begin
          busy_c        = 1'b1;
          cnt_clr       = 1'b1;
          miss_base_d   = bus.miss_address & BASE_MASK;
          victim_base_d = bus.victim_address & BASE_MASK;
          state_d       = bus.victim_dirty ? ST_WB : ST_FILL;
        end
      end
      ST_WB: begin
        busy_c    = 1'b1;
        wr_req_c  = 1'b1;
        rd_arr_c  = 1'b1;
        addr_c    = victim_base_q + word_off;
        arr_idx_c = idx;
        if (bus.mem_wr_ack) begin
          cnt_inc = 1'b1;
          if (idx_last) state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        busy_c    = 1'b1;
        rd_req_c  = 1'b1;
        addr_c    = miss_base_q + word_off;
        arr_idx_c = idx;
        if (bus.memory_data_valid) begin
          wr_arr_c = 1'b1;
          cnt_inc  = 1'b1;
          if (idx_last) state_d = ST_TAG;
        end
      end
      ST_TAG: begin
        busy_c  = 1'b1;
        tag_c   = 1'b1;
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.fsm_busy         = busy_c;
  assign bus.mem_rd_req       = rd_req_c;
  assign bus.mem_wr_req       = wr_req_c;
  assign bus.memory_address   = addr_c;
  assign bus.read_data_array  = rd_arr_c;
  assign bus.write_data_array = wr_arr_c;
  assign bus.write_tag_array  = tag_c;
  assign bus.array_word_idx   = arr_idx_c;
  assign bus.fill_done        = done_c;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: default geometry instance plus a
// 4-word/4-byte instance, each cycle compared against hand-computed values.
module tb_cache_fill_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cache_fill_ctrl_if #(.ADDR_W(16), .BLOCK_WORDS(8)) bus0 ();
  cache_fill_ctrl_if #(.ADDR_W(16), .BLOCK_WORDS(4)) bus1 ();

  cache_fill_ctrl #(.ADDR_W(16), .WORD_BYTES(2), .BLOCK_WORDS(8)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0));
  cache_fill_ctrl #(.ADDR_W(16), .WORD_BYTES(4), .BLOCK_WORDS(4)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1));

  // {busy, rd_req, wr_req, rd_arr, wr_arr, tag_wr, fill_done}
  localparam logic [6:0] C_IDLE  = 7'b0000000;
  localparam logic [6:0] C_ACC   = 7'b1000000;
  localparam logic [6:0] C_FILL  = 7'b1100000;
  localparam logic [6:0] C_FILLV = 7'b1100100;
  localparam logic [6:0] C_WB    = 7'b1011000;
  localparam logic [6:0] C_TAG   = 7'b1000011;

  function automatic logic [25:0] snap0();
    return {bus0.fsm_busy, bus0.mem_rd_req, bus0.mem_wr_req, bus0.read_data_array,
            bus0.write_data_array, bus0.write_tag_array, bus0.fill_done,
            bus0.memory_address, bus0.array_word_idx};
  endfunction

  function automatic logic [24:0] snap1();
    return {bus1.fsm_busy, bus1.mem_rd_req, bus1.mem_wr_req, bus1.read_data_array,
            bus1.write_data_array, bus1.write_tag_array, bus1.fill_done,
            bus1.memory_address, bus1.array_word_idx};
  endfunction

  task automatic step0(input logic miss, input logic [15:0] ma, input logic dirty,
                       input logic [15:0] va, input logic valid, input logic ack);
    @(negedge clk);
    bus0.miss_detected     = miss;
    bus0.miss_address      = ma;
    bus0.victim_dirty      = dirty;
    bus0.victim_address    = va;
    bus0.memory_data_valid = valid;
    bus0.mem_wr_ack        = ack;
    #1;
  endtask

  task automatic step1(input logic miss, input logic [15:0] ma, input logic valid);
    @(negedge clk);
    bus1.miss_detected     = miss;
    bus1.miss_address      = ma;
    bus1.victim_dirty      = 1'b0;
    bus1.victim_address    = 16'h0;
    bus1.memory_data_valid = valid;
    bus1.mem_wr_ack        = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [25:0] g0;
    logic [24:0] g1;
    rst = 1'b1;
    bus0.miss_detected = 1'b1; bus0.miss_address = 16'h1236; bus0.victim_dirty = 1'b1;
    bus0.victim_address = 16'h8008; bus0.memory_data_valid = 1'b1; bus0.mem_wr_ack = 1'b1;
    bus1.miss_detected = 1'b1; bus1.miss_address = 16'h0107; bus1.victim_dirty = 1'b0;
    bus1.victim_address = 16'h0; bus1.memory_data_valid = 1'b1; bus1.mem_wr_ack = 1'b0;
    @(negedge clk); #1;
    g0 = snap0(); g1 = snap1();
    checks++;
    if (g0 !== 26'h0) begin failures++; $display("FAIL reset_dut0 got=%h exp=0", g0); end
    checks++;
    if (g1 !== 25'h0) begin failures++; $display("FAIL reset_dut1 got=%h exp=0", g1); end
    step0(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    step1(1'b0, 16'h0, 1'b0);
    rst = 1'b0;
    #1;
    g0 = snap0();
    checks++;
    if (g0 !== {C_IDLE, 16'h0, 3'd0}) begin
      failures++; $display("FAIL reset_release got=%h exp=%h", g0, {C_IDLE, 16'h0, 3'd0});
    end
  endtask

  task automatic test_clean_fill();
    logic [25:0] g, e;
    step0(1'b1, 16'h1236, 1'b0, 16'h0, 1'b0, 1'b0);
    g = snap0(); e = {C_ACC, 16'h0, 3'd0}; checks++;
    if (g !== e) begin failures++; $display("FAIL clean_accept got=%h exp=%h", g, e); end
    for (int i = 0; i < 8; i++) begin
      step0(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
      g = snap0(); e = {C_FILLV, 16'(16'h1230 + 2 * i), 3'(i)}; checks++;
      if (g !== e) begin failures++; $display("FAIL clean_fill[%0d] got=%h exp=%h", i, g, e); end
    end
    step0(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    g = snap0(); e = {C_TAG, 16'h0, 3'd0}; checks++;
    if (g !== e) begin failures++; $display("FAIL clean_tag got=%h exp=%h", g, e); end
    step0(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    g = snap0(); e = {C_IDLE, 16'h0, 3'd0}; checks++;
    if (g !== e) begin failures++; $display("FAIL clean_idle got=%h exp=%h", g, e); end
  endtask

  task automatic test_dirty_wb();
    logic [25:0] g, e;
    step0(1'b1, 16'h0040, 1'b1, 16'h8008, 1'b0, 1'b0);
    g = snap0(); e = {C_ACC, 16'h0, 3'd0}; checks++;
    if (g !== e) begin failures++; $display("FAIL dirty_accept got=%h exp=%h", g, e); end
    for (int w = 0; w < 8; w++) begin
      for (int d = 0; d < 4; d++) begin
        // stray read-valid during write-back must not write the array
        step0(1'b0, 16'h0, 1'b0, 16'h0, 1'(d == 1), 1'(d == 3));
        g = snap0(); e = {C_WB, 16'(16'h8000 + 2 * w), 3'(w)}; checks++;
        if (g !== e) begin
          failures++; $display("FAIL dirty_wb[%0d.%0d] got=%h exp=%h", w, d, g, e);
        end
      end
    end
    for (int w = 0; w < 8; w++) begin
      step0(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'(w % 2));
      g = snap0(); e = {C_FILLV, 16'(16'h0040 + 2 * w), 3'(w)}; checks++;
      if (g !== e) begin failures++; $display("FAIL dirty_fill[%0d] got=%h exp=%h", w, g, e); end
    end
    step0(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    g = snap0(); e = {C_TAG, 16'h0, 3'd0}; checks++;
    if (g !== e) begin failures++; $display("FAIL dirty_tag got=%h exp=%h", g, e); end
    step0(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    logic [25:0] g, e;
    step0(1'b1, 16'hFFF2, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step0(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
      g = snap0(); e = {C_FILLV, 16'(16'hFFF0 + 2 * i), 3'(i)}; checks++;
      if (g !== e) begin failures++; $display("FAIL wrap_fill[%0d] got=%h exp=%h", i, g, e); end
    end
    step0(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    g = snap0(); e = {C_TAG, 16'h0, 3'd0}; checks++;
    if (g !== e) begin failures++; $display("FAIL wrap_tag got=%h exp=%h", g, e); end
    step0(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [25:0] g, e;
    step0(1'b1, 16'h2000, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step0(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
    step0(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
    g = snap0(); e = {C_FILLV, 16'h2008, 3'd4}; checks++;
    if (g !== e) begin failures++; $display("FAIL rstmid_pre got=%h exp=%h", g, e); end
    @(negedge clk);
    bus0.miss_detected = 1'b1; bus0.miss_address = 16'h3002;
    bus0.memory_data_valid = 1'b1; rst = 1'b1;
    #1;
    g = snap0(); e = 26'h0; checks++;
    if (g !== e) begin failures++; $display("FAIL rstmid_assert got=%h exp=%h", g, e); end
    @(negedge clk);
    rst = 1'b0; bus0.memory_data_valid = 1'b0;
    #1;
    g = snap0(); e = {C_ACC, 16'h0, 3'd0}; checks++;
    if (g !== e) begin failures++; $display("FAIL rstmid_accept got=%h exp=%h", g, e); end
    for (int i = 0; i < 8; i++) begin
      step0(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
      g = snap0(); e = {C_FILLV, 16'(16'h3000 + 2 * i), 3'(i)}; checks++;
      if (g !== e) begin failures++; $display("FAIL rstmid_fill[%0d] got=%h exp=%h", i, g, e); end
    end
    step0(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    g = snap0(); e = {C_TAG, 16'h0, 3'd0}; checks++;
    if (g !== e) begin failures++; $display("FAIL rstmid_tag got=%h exp=%h", g, e); end
    step0(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_ignored();
    logic [25:0] g, e;
    int w;
    for (int i = 0; i < 2; i++) begin
      step0(1'b0, 16'h1234, 1'b1, 16'h4000, 1'b1, 1'b1);
      g = snap0(); e = {C_IDLE, 16'h0, 3'd0}; checks++;
      if (g !== e) begin failures++; $display("FAIL ign_idle[%0d] got=%h exp=%h", i, g, e); end
    end
    step0(1'b1, 16'h0502, 1'b0, 16'h0, 1'b0, 1'b0);
    g = snap0(); e = {C_ACC, 16'h0, 3'd0}; checks++;
    if (g !== e) begin failures++; $display("FAIL ign_accept got=%h exp=%h", g, e); end
    w = 0;
    for (int k = 0; k < 40 && w < 8; k++) begin
      logic v;
      v = 1'(k % 3 != 1);
      step0(1'(k < 3), 16'h7776, 1'b1, 16'hC000, v, 1'b1);
      g = snap0(); e = {v ? C_FILLV : C_FILL, 16'(16'h0500 + 2 * w), 3'(w)}; checks++;
      if (g !== e) begin failures++; $display("FAIL ign_fill[%0d] got=%h exp=%h", k, g, e); end
      if (v) w++;
    end
    checks++;
    if (w !== 8) begin failures++; $display("FAIL ign_words got=%0d exp=8", w); end
    step0(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    g = snap0(); e = {C_TAG, 16'h0, 3'd0}; checks++;
    if (g !== e) begin failures++; $display("FAIL ign_tag got=%h exp=%h", g, e); end
    step0(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1);
    g = snap0(); e = {C_IDLE, 16'h0, 3'd0}; checks++;
    if (g !== e) begin failures++; $display("FAIL ign_after got=%h exp=%h", g, e); end
  endtask

  task automatic test_back_to_back();
    logic [25:0] g, e;
    step0(1'b1, 16'h0100, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step0(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
    step0(1'b1, 16'h0A06, 1'b0, 16'h0, 1'b0, 1'b0);
    g = snap0(); e = {C_TAG, 16'h0, 3'd0}; checks++;
    if (g !== e) begin failures++; $display("FAIL b2b_tag got=%h exp=%h", g, e); end
    step0(1'b1, 16'h0A06, 1'b0, 16'h0, 1'b0, 1'b0);
    g = snap0(); e = {C_ACC, 16'h0, 3'd0}; checks++;
    if (g !== e) begin failures++; $display("FAIL b2b_bubble got=%h exp=%h", g, e); end
    for (int i = 0; i < 8; i++) begin
      step0(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
      g = snap0(); e = {C_FILLV, 16'(16'h0A00 + 2 * i), 3'(i)}; checks++;
      if (g !== e) begin failures++; $display("FAIL b2b_fill[%0d] got=%h exp=%h", i, g, e); end
    end
    step0(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    g = snap0(); e = {C_TAG, 16'h0, 3'd0}; checks++;
    if (g !== e) begin failures++; $display("FAIL b2b_tag2 got=%h exp=%h", g, e); end
    step0(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_small_geometry();
    logic [24:0] g, e;
    step1(1'b1, 16'h0107, 1'b0);
    g = snap1(); e = {C_ACC, 16'h0, 2'd0}; checks++;
    if (g !== e) begin failures++; $display("FAIL small_accept got=%h exp=%h", g, e); end
    for (int i = 0; i < 4; i++) begin
      step1(1'b0, 16'h0, 1'b1);
      g = snap1(); e = {C_FILLV, 16'(16'h0100 + 4 * i), 2'(i)}; checks++;
      if (g !== e) begin failures++; $display("FAIL small_fill[%0d] got=%h exp=%h", i, g, e); end
    end
    step1(1'b0, 16'h0, 1'b0);
    g = snap1(); e = {C_TAG, 16'h0, 2'd0}; checks++;
    if (g !== e) begin failures++; $display("FAIL small_tag got=%h exp=%h", g, e); end
    step1(1'b0, 16'h0, 1'b0);
    g = snap1(); e = {C_IDLE, 16'h0, 2'd0}; checks++;
    if (g !== e) begin failures++; $display("FAIL small_idle got=%h exp=%h", g, e); end
  endtask

  initial begin
    test_reset();
    test_clean_fill();
    test_dirty_wb();
    test_wrap();
    test_reset_mid();
    test_ignored();
    test_back_to_back();
    test_small_geometry();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench exceeded its time limit");
  end

endmodule
